// File: rtl/regfile_ctrl_pkg.sv
// Shared op-codes, FSM state encoding and default widths for the register-file
// port controller.
package regfile_ctrl_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 8;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_RSP   = 3'd3,
      S_CP_RD = 3'd4,
      S_CP_WR = 3'd5,
      S_CLR   = 3'd6
   } state_t;

endpackage

// File: rtl/Register_File.sv
// Small register file: one synchronous write port, two combinational read
// ports, asynchronous active-high reset.
module Register_File #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr_1,
   input  logic [ADDR_W-1:0] read_addr_2,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (RegWrite) begin
         regs[write_addr] <= write_data;
      end
   end

   assign read_data_1 = regs[read_addr_1];
   assign read_data_2 = regs[read_addr_2];

endmodule

// File: rtl/regfile_port_ctrl.sv
// Command sequencer in front of Register_File: write, dual read with a
// valid/ready response, copy, and a sweep that zeroes every register.
module regfile_port_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr_a,
   input  logic [ADDR_W-1:0] cmd_addr_b,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data_1,
   output logic [DATA_W-1:0] rsp_data_2,
   output logic [ADDR_W-1:0] rf_read_addr_1,
   output logic [ADDR_W-1:0] rf_read_addr_2,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_RegWrite,
   input  logic [DATA_W-1:0] rf_read_data_1,
   input  logic [DATA_W-1:0] rf_read_data_2,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   state_t            state_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;

   assign cmd_ready = (state_reg == S_IDLE);
   assign busy      = (state_reg != S_IDLE);

   // rf_write_data doubles as the copy holding register: the source value is
   // captured straight into it during CP_RD and written out in CP_WR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         clr_cnt_reg    <= '0;
         rsp_valid      <= 1'b0;
         rsp_data_1     <= '0;
         rsp_data_2     <= '0;
         rf_read_addr_1 <= '0;
         rf_read_addr_2 <= '0;
         rf_write_addr  <= '0;
         rf_write_data  <= '0;
         rf_RegWrite    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_WRITE: begin
                        rf_write_addr <= cmd_addr_a;
                        rf_write_data <= cmd_data;
                        rf_RegWrite   <= 1'b1;
                        state_reg     <= S_WR;
                     end
                     OP_READ: begin
                        rf_read_addr_1 <= cmd_addr_a;
                        rf_read_addr_2 <= cmd_addr_b;
                        state_reg      <= S_RD;
                     end
                     OP_COPY: begin
                        rf_read_addr_1 <= cmd_addr_a;
                        rf_write_addr  <= cmd_addr_b;
                        state_reg      <= S_CP_RD;
                     end
                     default: begin
                        clr_cnt_reg   <= '0;
                        rf_write_addr <= '0;
                        rf_write_data <= '0;
                        rf_RegWrite   <= 1'b1;
                        state_reg     <= S_CLR;
                     end
                  endcase
               end
            end
            S_WR: begin
               rf_RegWrite <= 1'b0;
               state_reg   <= S_IDLE;
            end
            S_RD: begin
               rsp_data_1 <= rf_read_data_1;
               rsp_data_2 <= rf_read_data_2;
               rsp_valid  <= 1'b1;
               state_reg  <= S_RSP;
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            S_CP_RD: begin
               rf_write_data <= rf_read_data_1;
               rf_RegWrite   <= 1'b1;
               state_reg     <= S_CP_WR;
            end
            S_CP_WR: begin
               rf_RegWrite <= 1'b0;
               state_reg   <= S_IDLE;
            end
            S_CLR: begin
               if (clr_cnt_reg == CNT_LAST) begin
                  clr_cnt_reg <= '0;
                  rf_RegWrite <= 1'b0;
                  state_reg   <= S_IDLE;
               end else begin
                  clr_cnt_reg   <= clr_cnt_reg + 1'b1;
                  rf_write_addr <= clr_cnt_reg + 1'b1;
               end
            end
            default: begin
               rf_RegWrite <= 1'b0;
               rsp_valid   <= 1'b0;
               state_reg   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
